// File: rtl/trace_capture_unit.sv
// Retire-trace capture buffer: records {pc, instr, result} per retired instruction into a
// circular buffer, freezes on halt or PC match (with optional post-trigger window), then
// drains the frozen history over a valid/ready read port.
module trace_capture_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  enable,
  input  logic                  mode,
  input  logic                  retire,
  input  logic [DATA_WIDTH-1:0] pcIn,
  input  logic [DATA_WIDTH-1:0] instrIn,
  input  logic [DATA_WIDTH-1:0] resultIn,
  input  logic                  halt,
  input  logic                  trigPcEn,
  input  logic [DATA_WIDTH-1:0] trigPc,
  input  logic [CW-1:0]         postCount,
  input  logic                  rdReady,
  output logic                  rdValid,
  output logic [DATA_WIDTH-1:0] rdPc,
  output logic [DATA_WIDTH-1:0] rdInstr,
  output logic [DATA_WIDTH-1:0] rdResult,
  output logic [CW-1:0]         count,
  output logic [1:0]            state,
  output logic                  triggered,
  output logic                  overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   remaining_q, remaining_d;
  logic            triggered_q, triggered_d;
  logic            overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0] pc_mem     [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] result_mem [DEPTH];

  logic mem_we;
  logic full;
  logic pc_hit;
  logic trig;
  logic drop;
  logic captured;
  logic pop;

  // Decode capture/trigger conditions shared by the state logic.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    pc_hit   = retire && trigPcEn && (pcIn == trigPc);
    trig     = halt || pc_hit;
    // Fill-and-stop on a full buffer refuses the write and ends the run.
    drop     = retire && full && !mode;
    captured = retire && !drop;
    pop      = rdValid && rdReady;
  end

  // Next-state, pointer and flag update.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    triggered_d = triggered_q;
    overflow_d  = overflow_q;
    mem_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Retire in the arming cycle is intentionally ignored.
        if (enable) begin
          state_d     = StArmed;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
          remaining_d = '0;
          triggered_d = 1'b0;
          overflow_d  = 1'b0;
        end
      end

      StArmed, StPost: begin
        if (retire) begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CW'(1);
          end else if (mode) begin
            // Circular: overwrite the oldest entry, read pointer follows.
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + AW'(1);
            rd_ptr_d   = rd_ptr_q + AW'(1);
            overflow_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end

        if (state_q == StArmed) begin
          if (enable && trig) begin
            triggered_d = 1'b1;
          end
          if (!enable || drop) begin
            state_d = StDone;
          end else if (trig) begin
            if (postCount == '0) begin
              state_d = StDone;
            end else begin
              state_d     = StPost;
              remaining_d = postCount;
            end
          end
        end else begin
          if (captured) begin
            remaining_d = remaining_q - CW'(1);
          end
          if (!enable || drop || halt || (captured && remaining_q == CW'(1))) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        if (pop) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - CW'(1);
        end
        // Holding enable high parks here so a re-arm needs a fresh rising enable.
        if (count_q == '0 && !enable) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      triggered_q <= triggered_d;
      overflow_q  <= overflow_d;
    end
  end

  // Trace storage; contents are only observable through the gated read port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      pc_mem[wr_ptr_q]     <= pcIn;
      instr_mem[wr_ptr_q]  <= instrIn;
      result_mem[wr_ptr_q] <= resultIn;
    end
  end

  // Read port: head entry, forced to zero whenever nothing is presented.
  always_comb begin
    rdValid  = (state_q == StDone) && (count_q != '0);
    rdPc     = rdValid ? pc_mem[rd_ptr_q]     : '0;
    rdInstr  = rdValid ? instr_mem[rd_ptr_q]  : '0;
    rdResult = rdValid ? result_mem[rd_ptr_q] : '0;
  end

  // Status outputs.
  always_comb begin
    count     = count_q;
    state     = state_q;
    triggered = triggered_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_trace_capture_unit.sv
// Bench for trace_capture_unit: directed capture scenarios; expected drain entries are queued
// by the stimulus and checked by an independent read-port monitor.
module tb_trace_capture_unit;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
    logic [DW-1:0] result;
  } entry_t;

  logic          clk = 1'b0;
  logic          rstN;
  logic          enable;
  logic          mode;
  logic          retire;
  logic [DW-1:0] pcIn;
  logic [DW-1:0] instrIn;
  logic [DW-1:0] resultIn;
  logic          halt;
  logic          trigPcEn;
  logic [DW-1:0] trigPc;
  logic [CW-1:0] postCount;
  logic          rdReady;
  logic          rdValid;
  logic [DW-1:0] rdPc;
  logic [DW-1:0] rdInstr;
  logic [DW-1:0] rdResult;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic          triggered;
  logic          overflow;

  int     checks   = 0;
  int     failures = 0;
  entry_t exp_q[$];

  trace_capture_unit #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .CW        (CW)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .enable   (enable),
    .mode     (mode),
    .retire   (retire),
    .pcIn     (pcIn),
    .instrIn  (instrIn),
    .resultIn (resultIn),
    .halt     (halt),
    .trigPcEn (trigPcEn),
    .trigPc   (trigPc),
    .postCount(postCount),
    .rdReady  (rdReady),
    .rdValid  (rdValid),
    .rdPc     (rdPc),
    .rdInstr  (rdInstr),
    .rdResult (rdResult),
    .count    (count),
    .state    (state),
    .triggered(triggered),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] instr_of(input logic [DW-1:0] pc);
    return 32'h1300_0000 | pc;
  endfunction

  function automatic logic [DW-1:0] result_of(input logic [DW-1:0] pc);
    return ~pc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [DW-1:0] pc);
    entry_t e;
    e.pc     = pc;
    e.instr  = instr_of(pc);
    e.result = result_of(pc);
    exp_q.push_back(e);
  endtask

  task automatic do_retire(input logic [DW-1:0] pc, input logic h);
    retire   = 1'b1;
    pcIn     = pc;
    instrIn  = instr_of(pc);
    resultIn = result_of(pc);
    halt     = h;
    tick();
    retire   = 1'b0;
    halt     = 1'b0;
  endtask

  task automatic arm(input logic m);
    mode   = m;
    enable = 1'b1;
    tick();
    check("arm_state", 32'(state), 32'd1);
  endtask

  // Drain with enable low; ends back in IDLE.
  task automatic drain(input string tag);
    enable  = 1'b0;
    rdReady = 1'b1;
    for (int i = 0; i < 40 && rdValid; i++) tick();
    rdReady = 1'b0;
    check({tag, "_empty"}, 32'(rdValid), 32'd0);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    check({tag, "_idle"}, 32'(state), 32'd0);
  endtask

  // Read-port monitor: every accepted entry must match the queued expectation.
  always @(negedge clk) begin
    if (rstN && rdValid && rdReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got pc 0x%0h, expected no entry", rdPc);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        check("rd_pc", rdPc, e.pc);
        check("rd_instr", rdInstr, e.instr);
        check("rd_result", rdResult, e.result);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN      = 1'b0;
    enable    = 1'b0;
    mode      = 1'b0;
    retire    = 1'b0;
    pcIn      = '0;
    instrIn   = '0;
    resultIn  = '0;
    halt      = 1'b0;
    trigPcEn  = 1'b0;
    trigPc    = '0;
    postCount = '0;
    rdReady   = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(rdValid), 32'd0);
    check("rst_trig", 32'(triggered), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_rdpc", rdPc, 32'd0);
    rstN = 1'b1;
    tick();

    // Mode 0, 10 retires, stop with enable low.
    arm(1'b0);
    for (int i = 0; i < 10; i++) begin
      do_retire(32'(i * 4), 1'b0);
      push_exp(32'(i * 4));
    end
    check("t1_count", 32'(count), 32'd10);
    enable = 1'b0;
    tick();
    check("t1_state", 32'(state), 32'd3);
    check("t1_ovf", 32'(overflow), 32'd0);
    check("t1_trig", 32'(triggered), 32'd0);
    drain("t1");

    // Mode 0, 20 retires: 17th is dropped and freezes the buffer.
    arm(1'b0);
    for (int i = 0; i < 20; i++) begin
      do_retire(32'(i * 4), 1'b0);
      if (i < 16) push_exp(32'(i * 4));
      if (i == 15) check("t2_full_state", 32'(state), 32'd1);
      if (i == 16) check("t2_drop_state", 32'(state), 32'd3);
    end
    check("t2_count", 32'(count), 32'd16);
    check("t2_ovf", 32'(overflow), 32'd1);
    drain("t2");

    // Mode 1, 40 retires then halt with no post window.
    arm(1'b1);
    for (int i = 0; i < 40; i++) do_retire(32'(i * 4), 1'b0);
    for (int i = 24; i < 40; i++) push_exp(32'(i * 4));
    postCount = '0;
    halt      = 1'b1;
    tick();
    halt      = 1'b0;
    check("t3_state", 32'(state), 32'd3);
    check("t3_count", 32'(count), 32'd16);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_trig", 32'(triggered), 32'd1);
    drain("t3");

    // Mode 1, PC match at 0x40 with 3 post-trigger entries.
    trigPcEn  = 1'b1;
    trigPc    = 32'h40;
    postCount = CW'(3);
    arm(1'b1);
    for (int i = 0; i <= 24; i++) begin
      do_retire(32'(i * 4), 1'b0);
      if (i == 16) check("t4_post", 32'(state), 32'd2);
      if (i == 18) check("t4_still_post", 32'(state), 32'd2);
      if (i == 19) check("t4_done", 32'(state), 32'd3);
    end
    for (int i = 4; i < 20; i++) push_exp(32'(i * 4));
    check("t4_count", 32'(count), 32'd16);
    check("t4_trig", 32'(triggered), 32'd1);
    check("t4_ovf", 32'(overflow), 32'd1);
    trigPcEn = 1'b0;
    drain("t4");

    // POST window of 5 cut short by halt on the 2nd post-trigger retire.
    trigPcEn  = 1'b1;
    trigPc    = 32'h8;
    postCount = CW'(5);
    arm(1'b0);
    do_retire(32'h0, 1'b0);
    do_retire(32'h4, 1'b0);
    do_retire(32'h8, 1'b0);
    check("t5_post", 32'(state), 32'd2);
    do_retire(32'hC, 1'b0);
    do_retire(32'h10, 1'b1);
    check("t5_done", 32'(state), 32'd3);
    do_retire(32'h14, 1'b0);
    check("t5_count", 32'(count), 32'd5);
    check("t5_trig", 32'(triggered), 32'd1);
    check("t5_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) push_exp(32'(i * 4));
    trigPcEn = 1'b0;
    drain("t5");

    // Asynchronous reset while holding 7 entries in DONE.
    postCount = '0;
    arm(1'b0);
    for (int i = 0; i < 7; i++) do_retire(32'(i * 4), 1'b0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("t6_count", 32'(count), 32'd7);
    check("t6_valid", 32'(rdValid), 32'd1);
    check("t6_trig", 32'(triggered), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_valid", 32'(rdValid), 32'd0);
    check("t6_rst_state", 32'(state), 32'd0);
    check("t6_rst_trig", 32'(triggered), 32'd0);
    check("t6_rst_pc", rdPc, 32'd0);
    tick();
    rstN = 1'b1;
    tick();
    check("t6_rearm", 32'(state), 32'd1);
    check("t6_rearm_count", 32'(count), 32'd0);
    enable = 1'b0;
    tick();
    check("t6_done_empty", 32'(state), 32'd3);
    tick();
    check("t6_idle", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_capture_unit.md
# trace_capture_unit

Parametrised retire-trace capture buffer for the multicycle core. It records one entry of {pc, instruction, ALU result} per retired instruction into a circular buffer and freezes on a trigger: core halt or a PC match. An optional post-trigger window is captured before freezing, and the frozen trace is then drained over a valid/ready read port. It sits beside the processor wrapper and replaces ad-hoc probing of pc/instruction/aluResult with a bounded, replayable history.

## Interface
- DATA_WIDTH, 32, width of every captured field
- DEPTH, 16, buffer entries; power of two, at least 2
- CW, $clog2(DEPTH)+1, width of count and postCount (derived)

- clk  in  1  clock, rising edge
- rstN  in  1  reset; one clock; reset is asynchronous and active-low
- enable  in  1  arm request; level
- mode  in  1  0 = fill-and-stop, 1 = circular (overwrite oldest)
- retire  in  1  one-cycle strobe per retired instruction
- pcIn, instrIn, resultIn  in  DATA_WIDTH each  fields captured on retire
- halt  in  1  core halt; trigger source
- trigPcEn  in  1  enable PC-match trigger
- trigPc  in  DATA_WIDTH  PC-match value
- postCount  in  CW  entries to capture after trigger; sampled at trigger
- rdReady  in  1  consumer accepts head entry
- rdValid  out  1  head entry available
- rdPc, rdInstr, rdResult  out  DATA_WIDTH each  head entry fields
- count  out  CW  entries held
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- triggered  out  1  sticky; trigger occurred this run
- overflow  out  1  sticky; an entry was overwritten (mode 1) or dropped (mode 0)

## Operation
- IDLE: no capture. enable=1 clears wrPtr, rdPtr, count, triggered and overflow, then moves to ARMED.
- ARMED: every retire writes {pcIn, instrIn, resultIn} at wrPtr; wrPtr wraps modulo DEPTH.
  - Full with mode=1: write overwrites the oldest entry, rdPtr advances, count stays DEPTH, overflow sets.
  - Full with mode=0: write is dropped, overflow sets, state moves to DONE.
- Trigger = halt, or (retire and trigPcEn and pcIn==trigPc). On trigger, triggered sets. A trigger retire is itself captured.
  - postCount==0 moves to DONE.
  - Otherwise moves to POST and loads remaining=postCount.
- POST: captures as in ARMED and decrements remaining on each captured retire. remaining reaching 0 moves to DONE. halt in POST moves to DONE immediately; a retire in the same cycle is still captured. Full behaviour is the same as in ARMED.
- enable=0 in ARMED or POST moves to DONE without setting triggered.
- DONE: capture disabled.
  - rdValid = (count!=0).
  - rd* show mem[rdPtr] combinationally, stable while rdValid and !rdReady.
  - rdValid and rdReady together pop the entry: rdPtr+1 wraps, count-1.
  - count==0 with enable==0 moves to IDLE. enable held high keeps DONE with an empty buffer, so re-arming requires enable to drop then rise.
- rdValid is 0 in every state other than DONE.

## Timing
- Reset (rstN=0, asynchronous): state=IDLE, count=0, triggered=0, overflow=0, rdValid=0, rd* outputs=0, pointers=0. Reset mid-capture or mid-drain discards all contents.
- Capture: fields sampled on the rising edge where retire=1. count and wrPtr update on that same edge, so the new value is visible the next cycle.
- Trigger and state transitions take effect on the sampling edge. state shows the new value one cycle after the trigger cycle.
- Pop: handshake edge updates rdPtr and count. The next entry appears the following cycle. Sustained rdReady=1 drains one entry per cycle.
- IDLE to ARMED takes 1 cycle after enable is seen high. A retire in that arming cycle is not captured.
- count never exceeds DEPTH. The read and write ports are never active in the same state, so there is no simultaneous push and pop.

## Test plan
- Mode 0, DEPTH=16, 10 retires with pc=0x00..0x24 step 4, then enable=0 → DONE, count=10. Drain yields pc 0x00..0x24 in order, overflow=0, then IDLE.
- Mode 0, 20 retires → DONE after the 17th retire (drop), overflow=1, count=16. Drain yields the first 16 pcs.
- Mode 1, 40 retires, then halt with postCount=0 → count=16. Drain yields retires 25..40, overflow=1, triggered=1.
- Mode 1, trigPcEn=1, trigPc=0x40, postCount=3, retires pc 0x00..0x60 → state goes POST then DONE after pc 0x4C. Last entry drained is 0x4C, triggered=1.
- POST with remaining=5 and halt on the 2nd post-trigger retire → DONE. Both post-trigger retires are captured; there are no further captures.
- Assert rstN=0 mid-drain with count=7 → count=0, rdValid=0, state=IDLE, flags cleared. Releasing reset with enable=1 re-arms on the next edge.
